// File: rtl/serv_rf_ram_dbg.sv
// SERV register-file RAM with a side-band debug port.
// The CPU port always wins. Debug accesses move one RAM word per idle CPU cycle,
// stepping through the 32-bit register or CSR slot.
module serv_rf_ram_dbg #(
    parameter int WIDTH     = 8,
    parameter int RF_COUNT  = 16,
    parameter int CSR_COUNT = 8,
    parameter int L2D       = $clog2((RF_COUNT + CSR_COUNT) * 32 / WIDTH)
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [L2D-1:0]   i_waddr,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_wen,
    input  logic [L2D-1:0]   i_raddr,
    input  logic             i_ren,
    output logic [WIDTH-1:0] o_rdata,
    input  logic             i_dbg_req,
    input  logic             i_dbg_we,
    input  logic [5:0]       i_dbg_reg,
    input  logic [31:0]      i_dbg_wdata,
    output logic             o_dbg_ack,
    output logic [31:0]      o_dbg_rdata,
    output logic             o_dbg_err
);
    localparam int unsigned N     = 32 / WIDTH;
    localparam int unsigned TOTAL = RF_COUNT + CSR_COUNT;
    localparam int unsigned DEPTH = TOTAL * N;
    localparam int unsigned CW    = $clog2(N) + 1;

    typedef enum logic [1:0] {IDLE, CHK, XFER, DONE} state_t;

    state_t           state;
    state_t           state_nx;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             we_q;
    logic [5:0]       reg_q;
    logic [31:0]      wdata_q;
    logic             err_q;
    logic [CW-1:0]    cnt;
    logic             beat;
    logic             last_beat;
    logic             bad_reg;
    logic             zero_reg;
    logic [L2D-1:0]   dbg_addr;
    logic [WIDTH-1:0] dbg_wsel;
    logic [WIDTH-1:0] dbg_q;
    logic             rd_pend;
    logic [CW-1:0]    rd_k;
    logic             ram_we;
    logic [L2D-1:0]   ram_waddr;
    logic [WIDTH-1:0] ram_wdata;

    assign bad_reg   = {1'b0, reg_q} >= 7'(TOTAL);
    assign zero_reg  = (reg_q == '0);
    // A beat only goes out in a cycle the CPU leaves the RAM alone
    assign beat      = (state == XFER) && (cnt < CW'(N)) && !i_ren && !i_wen;
    assign last_beat = beat && (cnt == CW'(N - 1));
    assign dbg_addr  = L2D'(32'(reg_q) * N + 32'(cnt));

    assign ram_we    = i_wen || (beat && we_q);
    assign ram_waddr = i_wen ? i_waddr : dbg_addr;
    assign ram_wdata = i_wen ? i_wdata : dbg_wsel;

    assign o_dbg_ack = (state == DONE);
    assign o_dbg_err = (state == DONE) && err_q;

    // Select the debug write word for the current beat
    always_comb begin
        dbg_wsel = '0;
        for (int unsigned k = 0; k < N; k++) begin
            if (cnt == CW'(k)) dbg_wsel = wdata_q[k*WIDTH +: WIDTH];
        end
    end

    // Debug FSM state register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) state <= IDLE;
        else          state <= state_nx;
    end

    // Debug FSM next state; reads spend one more XFER cycle on the final capture
    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (i_dbg_req) state_nx = CHK;
            CHK:  state_nx = (bad_reg || zero_reg) ? DONE : XFER;
            XFER: begin
                if (we_q) begin
                    if (last_beat) state_nx = DONE;
                end else if (cnt == CW'(N)) begin
                    state_nx = DONE;
                end
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Debug request latch, beat counter and private read-capture path
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            we_q        <= 1'b0;
            reg_q       <= '0;
            wdata_q     <= '0;
            err_q       <= 1'b0;
            cnt         <= '0;
            rd_pend     <= 1'b0;
            rd_k        <= '0;
            o_dbg_rdata <= '0;
        end else begin
            rd_pend <= beat && !we_q;
            rd_k    <= cnt;
            if (state == IDLE && i_dbg_req) begin
                we_q    <= i_dbg_we;
                reg_q   <= i_dbg_reg;
                wdata_q <= i_dbg_wdata;
            end
            if (state == CHK) begin
                err_q <= bad_reg;
                cnt   <= '0;
                if (!bad_reg && zero_reg && !we_q) o_dbg_rdata <= '0;
            end
            if (beat) cnt <= cnt + 1'b1;
            if (rd_pend) begin
                for (int unsigned k = 0; k < N; k++) begin
                    if (rd_k == CW'(k)) o_dbg_rdata[k*WIDTH +: WIDTH] <= dbg_q;
                end
            end
        end
    end

    // RAM array: single write port shared by CPU and debug, plus the debug read port
    always_ff @(posedge i_clk) begin
        if (ram_we) mem[ram_waddr] <= ram_wdata;
        if (beat && !we_q) dbg_q <= mem[dbg_addr];
    end

    // CPU registered read port
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)   o_rdata <= '0;
        else if (i_ren) o_rdata <= mem[i_raddr];
    end
endmodule
